// File: rtl/axi_burst_ram_if.sv
// AXI4 channel bundle (AW/W/B/AR/R) between a NoC master and axi_burst_ram.
interface axi_burst_ram_if #(
  parameter int unsigned ID_W_WIDTH = 4,
  parameter int unsigned ID_R_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8
);
  localparam int unsigned StrbWidth = DATA_WIDTH / BYTE_WIDTH;

  logic [ID_W_WIDTH-1:0] aw_id;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]            aw_len;
  logic [1:0]            aw_burst;
  logic                  aw_valid;
  logic                  aw_ready;

  logic [DATA_WIDTH-1:0] w_data;
  logic [StrbWidth-1:0]  w_strb;
  logic                  w_last;
  logic                  w_valid;
  logic                  w_ready;

  logic [ID_W_WIDTH-1:0] b_id;
  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;

  logic [ID_R_WIDTH-1:0] ar_id;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic [1:0]            ar_burst;
  logic                  ar_valid;
  logic                  ar_ready;

  logic [ID_R_WIDTH-1:0] r_id;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_last;
  logic                  r_valid;
  logic                  r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_burst, aw_valid, input aw_ready,
    output w_data, w_strb, w_last, w_valid, input w_ready,
    input b_id, b_resp, b_valid, output b_ready,
    output ar_id, ar_addr, ar_len, ar_burst, ar_valid, input ar_ready,
    input r_id, r_data, r_resp, r_last, r_valid, output r_ready
  );

  modport slave (
    input aw_id, aw_addr, aw_len, aw_burst, aw_valid, output aw_ready,
    input w_data, w_strb, w_last, w_valid, output w_ready,
    output b_id, b_resp, b_valid, input b_ready,
    input ar_id, ar_addr, ar_len, ar_burst, ar_valid, output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid, input r_ready
  );
endinterface

// File: rtl/axi_burst_ram.sv
// AXI4 INCR-burst RAM target with independent write (port A) and read (port B) engines.
// Define AXI_RAM_WRAP_EN to honour WRAP bursts of 2/4/8/16 beats.
module axi_burst_ram #(
  parameter int unsigned ID_W_WIDTH = 4,
  parameter int unsigned ID_R_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  axi_burst_ram_if.slave bus
);
  localparam int unsigned NumBytes = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam int unsigned IdxW     = ADDR_WIDTH - OffW;
  localparam int unsigned Depth    = 2 ** IdxW;

  typedef logic [IdxW-1:0] idx_t;
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  logic [DATA_WIDTH-1:0] mem [Depth];

  // Bits set in hold stay fixed across a burst; the rest increment (wrap window).
  function automatic idx_t next_idx(idx_t idx, idx_t hold);
    idx_t inc;
    inc = idx + 1'b1;
    return (idx & hold) | (inc & ~hold);
  endfunction

  logic aw_hs, w_hs, ar_hs, pop, rd_en, rd_last;
  idx_t w_hold, r_hold;

  // ---------------- write engine ----------------
  w_state_e              w_state_q, w_state_d;
  idx_t                  w_idx_q;
  logic [7:0]            w_len_q, w_cnt_q;
  logic [ID_W_WIDTH-1:0] w_id_q;

  assign aw_hs = bus.aw_valid && bus.aw_ready;
  assign w_hs  = bus.w_valid && bus.w_ready;

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle:   if (aw_hs) w_state_d = WData;
      WData:   if (w_hs && (w_cnt_q == w_len_q)) w_state_d = WResp;
      WResp:   if (bus.b_ready) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= WIdle;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_id_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) begin
        w_id_q  <= bus.aw_id;
        w_idx_q <= bus.aw_addr[ADDR_WIDTH-1:OffW];
        w_len_q <= bus.aw_len;
        w_cnt_q <= '0;
      end else if (w_hs) begin
        w_idx_q <= next_idx(w_idx_q, w_hold);
        w_cnt_q <= w_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (bus.w_strb[i]) mem[w_idx_q][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.w_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign bus.aw_ready = (w_state_q == WIdle);
  assign bus.w_ready  = (w_state_q == WData);
  assign bus.b_valid  = (w_state_q == WResp);
  assign bus.b_id     = w_id_q;
  assign bus.b_resp   = 2'b00;

  // ---------------- read engine ----------------
  r_state_e              r_state_q, r_state_d;
  idx_t                  r_idx_q;
  logic [7:0]            r_len_q;
  logic [8:0]            r_iss_q;
  logic [ID_R_WIDTH-1:0] r_id_q;
  logic [DATA_WIDTH-1:0] out_data_q, skid_data_q;
  logic                  out_valid_q, out_last_q, skid_valid_q, skid_last_q;

  assign ar_hs   = bus.ar_valid && bus.ar_ready;
  assign pop     = out_valid_q && bus.r_ready;
  assign rd_last = (r_iss_q == {1'b0, r_len_q});
  // Issue only while a slot in the out/skid pair will be free after this edge.
  assign rd_en   = (r_state_q == RData) && (r_iss_q <= {1'b0, r_len_q}) &&
                   !(out_valid_q && skid_valid_q && !pop);

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle:   if (ar_hs) r_state_d = RData;
      RData:   if (pop && out_last_q) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  // Port-B reads sample mem before the write port's update lands: read-first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q    <= RIdle;
      r_idx_q      <= '0;
      r_len_q      <= '0;
      r_iss_q      <= '0;
      r_id_q       <= '0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        r_id_q  <= bus.ar_id;
        r_idx_q <= bus.ar_addr[ADDR_WIDTH-1:OffW];
        r_len_q <= bus.ar_len;
        r_iss_q <= '0;
      end else if (rd_en) begin
        r_idx_q <= next_idx(r_idx_q, r_hold);
        r_iss_q <= r_iss_q + 9'd1;
      end
      if (!out_valid_q || pop) begin
        if (skid_valid_q) begin
          out_data_q   <= skid_data_q;
          out_last_q   <= skid_last_q;
          out_valid_q  <= 1'b1;
          skid_valid_q <= rd_en;
          if (rd_en) begin
            skid_data_q <= mem[r_idx_q];
            skid_last_q <= rd_last;
          end
        end else begin
          out_valid_q <= rd_en;
          if (rd_en) begin
            out_data_q <= mem[r_idx_q];
            out_last_q <= rd_last;
          end
        end
      end else if (rd_en) begin
        skid_data_q  <= mem[r_idx_q];
        skid_last_q  <= rd_last;
        skid_valid_q <= 1'b1;
      end
    end
  end

  assign bus.ar_ready = (r_state_q == RIdle);
  assign bus.r_valid  = out_valid_q;
  assign bus.r_data   = out_data_q;
  assign bus.r_last   = out_last_q;
  assign bus.r_id     = r_id_q;
  assign bus.r_resp   = 2'b00;

`ifdef AXI_RAM_WRAP_EN
  function automatic idx_t hold_mask(logic [1:0] burst, logic [7:0] len);
    if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      return ~idx_t'(len);
    end
    return '0;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_hold <= '0;
      r_hold <= '0;
    end else begin
      if (aw_hs) w_hold <= hold_mask(bus.aw_burst, bus.aw_len);
      if (ar_hs) r_hold <= hold_mask(bus.ar_burst, bus.ar_len);
    end
  end
`else
  assign w_hold = '0;
  assign r_hold = '0;
`endif

  // w_last, burst type in INCR-only builds and sub-word address bits carry no information.
  logic unused_ok;
  assign unused_ok = ^{bus.w_last, bus.aw_burst, bus.ar_burst,
                       bus.aw_addr[OffW-1:0], bus.ar_addr[OffW-1:0]};
endmodule

// File: tb/tb_axi_burst_ram.sv
// Scoreboard bench for axi_burst_ram: tasks push expected B/R responses, a monitor pops them.
module tb_axi_burst_ram;
  localparam int unsigned IdW   = 4;
  localparam int unsigned AddrW = 16;
  localparam int unsigned DataW = 32;
  localparam int unsigned ByteW = 8;
  localparam int Depth   = 16384;
  localparam int Timeout = 1000;
`ifdef AXI_RAM_WRAP_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int rr_mode = 0;  // 0: r_ready high, 1: toggle, 2: random, else low
  int b_mode = 0;   // 0: b_ready high, 1: random
  logic [31:0] mdl [Depth];
  logic [38:0] r_exp [$];
  logic [5:0]  b_exp [$];
  logic [38:0] r_e;
  logic [5:0]  b_e;
  logic        r_stall = 1'b0;
  logic [37:0] stall_snap = '0;

  always #5 clk = ~clk;

  axi_burst_ram_if #(.ID_W_WIDTH(IdW), .ID_R_WIDTH(IdW), .ADDR_WIDTH(AddrW),
                     .DATA_WIDTH(DataW), .BYTE_WIDTH(ByteW)) bus ();

  axi_burst_ram #(.ID_W_WIDTH(IdW), .ID_R_WIDTH(IdW), .ADDR_WIDTH(AddrW),
                  .DATA_WIDTH(DataW), .BYTE_WIDTH(ByteW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  // Word touched by beat i of a burst, straight from the address rules.
  function automatic int beat_idx(input int start, input int len, input logic [1:0] burst,
                                  input int i);
    int n, base;
    n = len + 1;
    if (WrapEn && burst == 2'b10 && (n == 2 || n == 4 || n == 8 || n == 16)) begin
      base = start - (start % n);
      return base + ((start - base + i) % n);
    end
    return (start + i) % Depth;
  endfunction

  task automatic do_write(input int addr, input int len, input logic [1:0] burst,
                          input logic [3:0] id, input logic [31:0] d0, input logic [3:0] s0,
                          input bit rnd);
    int start, t, idx;
    logic [31:0] d;
    logic [3:0]  s;
    start = (addr / 4) % Depth;
    @(posedge clk); #1;
    bus.aw_id = id; bus.aw_addr = addr[15:0]; bus.aw_len = len[7:0];
    bus.aw_burst = burst; bus.aw_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.aw_ready && t < Timeout);
    if (!bus.aw_ready) begin fail("aw_handshake"); bus.aw_valid = 1'b0; return; end
    @(posedge clk); #1;
    bus.aw_valid = 1'b0;
    @(negedge clk);
    check("w_ready_after_aw", 64'(bus.w_ready), 64'd1);
    for (int i = 0; i <= len; i++) begin
      @(posedge clk); #1;
      if (rnd && $urandom_range(0, 3) == 0) begin
        bus.w_valid = 1'b0;
        @(posedge clk); #1;
      end
      d = (rnd || i > 0) ? $urandom : d0;
      s = rnd ? 4'($urandom) : s0;
      bus.w_data = d; bus.w_strb = s; bus.w_last = (i == len); bus.w_valid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!bus.w_ready && t < Timeout);
      if (!bus.w_ready) begin fail("w_handshake"); bus.w_valid = 1'b0; return; end
      idx = beat_idx(start, len, burst, i);
      for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
    end
    @(posedge clk); #1;
    bus.w_valid = 1'b0;
    b_exp.push_back({id, 2'b00});
    @(negedge clk);
    check("b_valid_after_last_w", 64'(bus.b_valid), 64'd1);
    t = 0;
    while (!(bus.b_valid && bus.b_ready) && t < Timeout) begin @(negedge clk); t++; end
    if (t >= Timeout) begin fail("b_handshake"); return; end
    @(posedge clk); #1;
    @(negedge clk);
    check("aw_ready_after_b", 64'(bus.aw_ready), 64'd1);
  endtask

  task automatic do_read(input int addr, input int len, input logic [1:0] burst,
                         input logic [3:0] id);
    int start, t, cyc;
    start = (addr / 4) % Depth;
    for (int i = 0; i <= len; i++) begin
      r_exp.push_back({id, mdl[beat_idx(start, len, burst, i)], (i == len), 2'b00});
    end
    @(posedge clk); #1;
    bus.ar_id = id; bus.ar_addr = addr[15:0]; bus.ar_len = len[7:0];
    bus.ar_burst = burst; bus.ar_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.ar_ready && t < Timeout);
    if (!bus.ar_ready) begin fail("ar_handshake"); bus.ar_valid = 1'b0; return; end
    @(posedge clk); #1;
    bus.ar_valid = 1'b0;
    @(negedge clk);
    check("r_valid_lat1", 64'(bus.r_valid), 64'd0);
    @(negedge clk);
    check("r_valid_lat2", 64'(bus.r_valid), 64'd1);
    cyc = 1;
    t = 0;
    while (!(bus.r_valid && bus.r_ready && bus.r_last) && t < Timeout) begin
      @(negedge clk); cyc++; t++;
    end
    if (t >= Timeout) begin fail("r_last_handshake"); return; end
    if (rr_mode == 0) check("r_no_bubble_cycles", 64'(cyc), 64'(len + 1));
    @(posedge clk); #1;
    @(negedge clk);
    check("ar_ready_after_last_r", 64'(bus.ar_ready), 64'd1);
  endtask

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       bus.r_ready = 1'b1;
      1:       bus.r_ready = ~bus.r_ready;
      2:       bus.r_ready = 1'($urandom);
      default: bus.r_ready = 1'b0;
    endcase
    bus.b_ready = (b_mode == 0) ? 1'b1 : 1'($urandom);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.b_valid && bus.b_ready) begin
        if (b_exp.size() == 0) fail("b_unexpected");
        else begin
          b_e = b_exp.pop_front();
          check("b_resp_id", 64'({bus.b_id, bus.b_resp}), 64'(b_e));
        end
      end
      if (bus.r_valid && bus.r_ready) begin
        if (r_exp.size() == 0) fail("r_unexpected");
        else begin
          r_e = r_exp.pop_front();
          check("r_beat", 64'({bus.r_id, bus.r_data, bus.r_last, bus.r_resp}), 64'(r_e));
        end
      end
      if (r_stall) begin
        check("r_stall_hold", 64'({bus.r_valid, bus.r_data, bus.r_id, bus.r_last}),
              64'(stall_snap));
      end
      r_stall    <= bus.r_valid && !bus.r_ready;
      stall_snap <= {bus.r_valid, bus.r_data, bus.r_id, bus.r_last};
    end else begin
      r_stall <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1);
  end

  initial begin
    bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_burst = 2'b01; bus.aw_valid = 1'b0;
    bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0; bus.w_valid = 1'b0;
    bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_burst = 2'b01; bus.ar_valid = 1'b0;
    bus.r_ready = 1'b1; bus.b_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_readies", 64'({bus.aw_ready, bus.ar_ready}), 64'h3);
    check("rst_valids", 64'({bus.w_ready, bus.b_valid, bus.r_valid, bus.r_last}), 64'h0);
    check("rst_fields", 64'({bus.b_id, bus.r_id, bus.r_data, bus.b_resp, bus.r_resp}), 64'h0);
    rst_n = 1'b1;

    do_write(32'h10, 0, 2'b01, 4'h3, 32'hDEADBEEF, 4'hF, 1'b0);
    do_read(32'h10, 0, 2'b01, 4'h3);
    do_write(32'h10, 0, 2'b01, 4'h1, 32'h11223344, 4'b0101, 1'b0);
    do_read(32'h10, 0, 2'b01, 4'h2);

    // Fill words 0..255 so later random strobes always land on known bytes.
    do_write(32'h0, 255, 2'b01, 4'h2, $urandom, 4'hF, 1'b0);

    do_write(32'hFFFC, 3, 2'b01, 4'h5, $urandom, 4'hF, 1'b0);
    do_read(32'hFFFC, 3, 2'b01, 4'h6);

    do_write(32'h08, 3, 2'b10, 4'h7, $urandom, 4'hF, 1'b0);
    for (int a = 0; a <= 20; a += 4) do_read(a, 0, 2'b01, 4'h1);
    do_read(32'h08, 3, 2'b10, 4'h2);

    rr_mode = 1;
    fork
      do_write(32'h100, 7, 2'b01, 4'hA, $urandom, 4'hF, 1'b0);
      do_read(32'h200, 7, 2'b01, 4'hB);
    join

    b_mode = 1;
    rr_mode = 2;
    for (int k = 0; k < 40; k++) begin
      int a, l;
      logic [1:0] bu;
      l  = $urandom_range(0, 15);
      a  = $urandom_range(0, 255 - 15) * 4;
      bu = 2'($urandom);
      if ($urandom_range(0, 1) == 0) do_write(a, l, bu, 4'($urandom), 32'h0, 4'h0, 1'b1);
      else do_read(a, l, bu, 4'($urandom));
    end
    b_mode = 0;

    // Reset while a stalled read burst holds beats in the output buffer.
    rr_mode = 3;
    @(posedge clk); #1;
    bus.ar_id = 4'h9; bus.ar_addr = 16'h0040; bus.ar_len = 8'd15;
    bus.ar_burst = 2'b01; bus.ar_valid = 1'b1;
    @(negedge clk);
    check("ar_ready_before_rst", 64'(bus.ar_ready), 64'd1);
    @(posedge clk); #1;
    bus.ar_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("r_valid_before_rst", 64'(bus.r_valid), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_r_valid", 64'(bus.r_valid), 64'd0);
    check("rst_mid_ar_ready", 64'(bus.ar_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rr_mode = 0;
    do_read(32'h40, 15, 2'b01, 4'h9);

    repeat (3) @(negedge clk);
    check("r_queue_empty", 64'(r_exp.size()), 64'd0);
    check("b_queue_empty", 64'(b_exp.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_burst_ram.md
# axi_burst_ram

AXI4 burst-capable slave RAM, the parametrised successor to the single-beat AXI RAM wrapper. It owns a simple dual-port byte-enabled memory array: port A is driven by the write channel and port B by the read channel, so reads and writes progress concurrently. It supports INCR bursts up to 256 beats and ID echo. It sits at an NoC endpoint as a memory target.

## Interface
- ID_W_WIDTH, 4, write ID width
- ID_R_WIDTH, 4, read ID width
- ADDR_WIDTH, 16, byte address width; depth = 2^ADDR_WIDTH / (DATA_WIDTH/BYTE_WIDTH) words
- DATA_WIDTH, 32, data width; power of two, multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, strobe granularity
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- aw_id / aw_addr / aw_len / aw_burst  in  ID_W_WIDTH / ADDR_WIDTH / 8 / 2  write address fields
- aw_valid in 1, aw_ready out 1  AW handshake
- w_data / w_strb / w_last  in  DATA_WIDTH / DATA_WIDTH/BYTE_WIDTH / 1  write beat
- w_valid in 1, w_ready out 1  W handshake
- b_id / b_resp  out  ID_W_WIDTH / 2  write response
- b_valid out 1, b_ready in 1  B handshake
- ar_id / ar_addr / ar_len / ar_burst  in  ID_R_WIDTH / ADDR_WIDTH / 8 / 2  read address fields
- ar_valid in 1, ar_ready out 1  AR handshake
- r_id / r_data / r_resp / r_last  out  ID_R_WIDTH / DATA_WIDTH / 2 / 1  read beat
- r_valid out 1, r_ready in 1  R handshake

## Operation
- Word index = addr >> log2(DATA_WIDTH/BYTE_WIDTH); low address bits ignored (always full-width beats).
- Write FSM: W_IDLE (aw_ready=1) -> on AW handshake latch id/index/len/burst -> W_DATA (w_ready=1). Each W handshake writes bytes with w_strb[i]=1; beat counter counts up to aw_len+1 -> W_RESP (b_valid=1, b_resp=2'b00, b_id=latched id) -> on b_ready -> W_IDLE.
- Burst end is set by the beat count only; w_last is ignored.
- Read FSM: R_IDLE (ar_ready=1) -> on AR handshake -> R_DATA. It issues synchronous port-B reads ahead into a 2-entry output buffer. r_last=1 on beat ar_len+1. It returns to R_IDLE once the last beat is handshaken. r_resp is always 2'b00.
- INCR: index+1 per beat, modulo depth (wraps at top of memory).
- aw_burst/ar_burst FIXED (2'b00) and reserved (2'b11) are treated as INCR.
- Simultaneous AW and AR are accepted independently in the same cycle.
- Same-word read and write in one cycle: read returns the pre-write data (read-first).
- Reset: both FSMs go to IDLE and buffers are emptied; memory contents are retained, not cleared.

## Timing
- Reset values: aw_ready=1, ar_ready=1, w_ready=0, b_valid=0, r_valid=0, r_last=0, b_id=0, r_id=0, r_data=0, b_resp=0, r_resp=0.
- w_ready rises the cycle after the AW handshake.
- b_valid rises the cycle after the last W handshake.
- Next aw_ready comes the cycle after the B handshake.
- First r_valid comes 2 cycles after the AR handshake.
- With r_ready held high: one beat per cycle, no bubbles.
- r_ready low stalls output: r_data/r_id/r_last are held stable and no buffered beat is lost.
- Next ar_ready comes the cycle after the last R handshake.
- A valid is never deasserted before its handshake; outputs are registered.

## Configuration
- AXI_RAM_WRAP_EN defined: aw_burst/ar_burst = 2'b10 selects WRAP.
  - len+1 must be in {2,4,8,16}.
  - The index wraps within a (len+1)-word aligned window.
  - Any other length is treated as INCR.
- AXI_RAM_WRAP_EN undefined: 2'b10 is treated as INCR, and no wrap logic is built.

## Test plan
- Reset, then a single-beat write: addr 0x10, data 0xDEADBEEF, strb 4'hF, id 3 -> b_id=3, b_resp=0. Read 0x10 -> r_data=0xDEADBEEF, r_last=1, r_id=3.
- Partial strobe: addr 0x10 strb 4'b0101 data 0x11223344 over 0xDEADBEEF -> readback 0xDE22BE44.
- INCR len=3 write at the top word (0xFFFC), then readback with r_ready always 1 -> words at 0xFFFC, 0x0000, 0x0004, 0x0008. Four consecutive r_valid cycles; r_last on the 4th only.
- Concurrent write burst (len=7) and read burst (len=7) on disjoint addresses, r_ready toggling 1/0 -> all 8 read beats correct and in order, and the write completes with one B response.
- WRAP (macro on) len=3 at 0x08 -> beats hit 0x08, 0x0C, 0x00, 0x04. With the macro off -> 0x08, 0x0C, 0x10, 0x14.
- rst_n asserted mid-read burst -> r_valid=0 and ar_ready=1 immediately. A post-reset read of previously written data returns the retained values.
